// File: rtl/iob_sync_assim_fifo_r_big_pkg.sv
// Shared constants, configuration checks and helper types for the
// narrow-write / wide-read packing FIFO and its banked memory.
package iob_sync_assim_fifo_r_big_pkg;

  // Number of narrow words packed into one wide word.
  function automatic int fifo_ratio(input int w_data_w, input int r_data_w);
    return r_data_w / w_data_w;
  endfunction

  function automatic int fifo_log2ratio(input int w_data_w, input int r_data_w);
    return $clog2(r_data_w / w_data_w);
  endfunction

  function automatic int fifo_depth(input int addr_w);
    return 2 ** addr_w;
  endfunction

  // Wide width must be the narrow width times a power of two (at least 2),
  // and the FIFO must hold more than one wide word.
  function automatic bit fifo_cfg_ok(input int w_data_w, input int r_data_w, input int addr_w);
    int ratio;
    ratio = r_data_w / w_data_w;
    return (w_data_w > 0) && (r_data_w % w_data_w == 0) && (ratio >= 2) &&
           ((ratio & (ratio - 1)) == 0) && (addr_w > $clog2(ratio));
  endfunction

  typedef struct packed {
    logic write;
    logic read;
  } accept_t;

endpackage

// File: rtl/iob_2p_assim_sync_mem_r_big.sv
// Single-clock RAM: narrow write port, wide registered read port built from
// RATIO narrow banks read in parallel (bank 0 in the LSBs).
module iob_2p_assim_sync_mem_r_big
  import iob_sync_assim_fifo_r_big_pkg::*;
#(
  parameter int W_DATA_W = 8,
  parameter int R_DATA_W = 32,
  parameter int ADDR_W   = 6,
  localparam int LOG2RATIO = fifo_log2ratio(W_DATA_W, R_DATA_W),
  localparam int R_ADDR_W  = ADDR_W - LOG2RATIO
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                w_en,
  input  logic [ADDR_W-1:0]   w_addr,
  input  logic [W_DATA_W-1:0] w_data,
  input  logic                r_en,
  input  logic [R_ADDR_W-1:0] r_addr,
  output logic [R_DATA_W-1:0] r_data
);

  localparam int RATIO      = fifo_ratio(W_DATA_W, R_DATA_W);
  localparam int BANK_DEPTH = fifo_depth(ADDR_W) / RATIO;

  if (!fifo_cfg_ok(W_DATA_W, R_DATA_W, ADDR_W)) begin : g_bad_cfg
    $error("iob_2p_assim_sync_mem_r_big: unsupported width/address configuration");
  end

  logic [W_DATA_W-1:0] bank_rd [RATIO];
  logic [R_DATA_W-1:0] rd_word;
  logic [LOG2RATIO-1:0] w_bank;
  logic [R_ADDR_W-1:0]  w_row;

  assign w_bank = w_addr[LOG2RATIO-1:0];
  assign w_row  = w_addr[ADDR_W-1:LOG2RATIO];

  for (genvar b = 0; b < RATIO; b++) begin : g_bank
    localparam logic [LOG2RATIO-1:0] BANK_ID = LOG2RATIO'(b);
    logic [W_DATA_W-1:0] mem [BANK_DEPTH];

    always_ff @(posedge clk) begin
      if (w_en && (w_bank == BANK_ID)) begin
        mem[w_row] <= w_data;
      end
    end

    assign bank_rd[b] = mem[r_addr];
  end

  always_comb begin
    rd_word = '0;
    for (int b = 0; b < RATIO; b++) begin
      rd_word[b*W_DATA_W +: W_DATA_W] = bank_rd[b];
    end
  end

  // Output register holds its value between accepted reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data <= '0;
    end else if (r_en) begin
      r_data <= rd_word;
    end
  end

endmodule

// File: rtl/iob_sync_assim_fifo_r_big.sv
// Single-clock asymmetric FIFO: narrow words in, packed wide words out with
// the oldest narrow word in the least-significant slice.
module iob_sync_assim_fifo_r_big
  import iob_sync_assim_fifo_r_big_pkg::*;
#(
  parameter int W_DATA_W = 8,
  parameter int R_DATA_W = 32,
  parameter int ADDR_W   = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                w_en,
  input  logic [W_DATA_W-1:0] w_data,
  output logic                w_full,
  input  logic                r_en,
  output logic [R_DATA_W-1:0] r_data,
  output logic                r_empty,
  output logic [ADDR_W:0]     level
);

  localparam int RATIO     = fifo_ratio(W_DATA_W, R_DATA_W);
  localparam int LOG2RATIO = fifo_log2ratio(W_DATA_W, R_DATA_W);
  localparam int DEPTH     = fifo_depth(ADDR_W);
  localparam int R_ADDR_W  = ADDR_W - LOG2RATIO;

  localparam logic [ADDR_W:0] LVL_DEPTH = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] LVL_RATIO = (ADDR_W + 1)'(RATIO);

  if (!fifo_cfg_ok(W_DATA_W, R_DATA_W, ADDR_W)) begin : g_bad_cfg
    $error("iob_sync_assim_fifo_r_big: unsupported width/address configuration");
  end

  logic [ADDR_W-1:0]   wptr;
  logic [R_ADDR_W-1:0] rptr;
  accept_t             acc;
  logic [ADDR_W:0]     level_next;

  // Flags decode the registered level, so both accepts see pre-cycle state.
  assign w_full  = (level == LVL_DEPTH);
  assign r_empty = (level < LVL_RATIO);

  always_comb begin
    acc.write  = w_en & ~w_full;
    acc.read   = r_en & ~r_empty;
    level_next = level;
    if (acc.write) begin
      level_next = level_next + (ADDR_W + 1)'(1);
    end
    if (acc.read) begin
      level_next = level_next - LVL_RATIO;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      level <= level_next;
      if (acc.write) begin
        wptr <= wptr + ADDR_W'(1);
      end
      if (acc.read) begin
        rptr <= rptr + R_ADDR_W'(1);
      end
    end
  end

  iob_2p_assim_sync_mem_r_big #(
    .W_DATA_W (W_DATA_W),
    .R_DATA_W (R_DATA_W),
    .ADDR_W   (ADDR_W)
  ) u_mem (
    .clk    (clk),
    .rst    (rst),
    .w_en   (acc.write),
    .w_addr (wptr),
    .w_data (w_data),
    .r_en   (acc.read),
    .r_addr (rptr),
    .r_data (r_data)
  );

endmodule

// File: tb/tb_iob_sync_assim_fifo_r_big.sv
// Directed self-checking bench for the packing FIFO (8-bit in, 32-bit out,
// 16 narrow words deep).
module tb_iob_sync_assim_fifo_r_big;

  logic        clk;
  logic        rst;
  logic        w_en;
  logic [7:0]  w_data;
  logic        w_full;
  logic        r_en;
  logic [31:0] r_data;
  logic        r_empty;
  logic [4:0]  level;

  int vectors;
  int miscompares;

  iob_sync_assim_fifo_r_big #(
    .W_DATA_W (8),
    .R_DATA_W (32),
    .ADDR_W   (4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .w_en    (w_en),
    .w_data  (w_data),
    .w_full  (w_full),
    .r_en    (r_en),
    .r_data  (r_data),
    .r_empty (r_empty),
    .level   (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of requests, then settle 1 time unit past the edge.
  task automatic applyStimulus(input logic we, input logic [7:0] wd, input logic re);
    w_en   = we;
    w_data = wd;
    r_en   = re;
    @(posedge clk);
    #1;
    w_en = 1'b0;
    r_en = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  task automatic checkState(input string tag, input int exp_level, input logic exp_empty, input logic exp_full);
    checkOutput({tag, "_level"}, 32'(level), 32'(exp_level));
    checkOutput({tag, "_empty"}, 32'(r_empty), 32'(exp_empty));
    checkOutput({tag, "_full"}, 32'(w_full), 32'(exp_full));
  endtask

  function automatic logic [31:0] packWord(input int first);
    return {8'(first + 3), 8'(first + 2), 8'(first + 1), 8'(first)};
  endfunction

  int      n_wr;
  int      n_rd;
  logic    do_rd;
  logic    do_wr;

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst    = 1'b1;
    w_en   = 1'b0;
    w_data = 8'h00;
    r_en   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset and idle
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkState("reset", 0, 1'b1, 1'b0);
    checkOutput("reset_rdata", r_data, 32'h0000_0000);

    // Partial word, then 4th byte with a same-cycle read that must be rejected
    applyStimulus(1'b1, 8'h11, 1'b0);
    applyStimulus(1'b1, 8'h22, 1'b0);
    applyStimulus(1'b1, 8'h33, 1'b0);
    checkState("partial3", 3, 1'b1, 1'b0);
    applyStimulus(1'b1, 8'h44, 1'b1);
    checkState("fourth_byte", 4, 1'b0, 1'b0);
    checkOutput("rd_rejected_rdata", r_data, 32'h0000_0000);
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("first_word", r_data, 32'h4433_2211);
    checkState("after_first_read", 0, 1'b1, 1'b0);

    // Fill to full, drop a write while full
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 8'(i), 1'b0);
    checkState("full", 16, 1'b0, 1'b1);
    applyStimulus(1'b1, 8'hFF, 1'b0);
    checkState("write_when_full", 16, 1'b0, 1'b1);

    // Read while full with a same-cycle write: write still rejected
    applyStimulus(1'b1, 8'hFE, 1'b1);
    checkOutput("drain0", r_data, 32'h0302_0100);
    checkState("drain0", 12, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("drain1", r_data, 32'h0706_0504);
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("drain2", r_data, 32'h0B0A_0908);
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("drain3", r_data, 32'h0F0E_0D0C);
    checkState("drained", 0, 1'b1, 1'b0);

    // Concurrent write and read at level 4
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 8'(8'h50 + i), 1'b0);
    applyStimulus(1'b1, 8'hAA, 1'b1);
    checkState("concurrent", 1, 1'b1, 1'b0);
    checkOutput("concurrent_rdata", r_data, 32'h5352_5150);

    // Read while empty changes nothing; following word proves rptr held
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkState("read_empty", 1, 1'b1, 1'b0);
    checkOutput("read_empty_rdata", r_data, 32'h5352_5150);
    applyStimulus(1'b1, 8'hBB, 1'b0);
    applyStimulus(1'b1, 8'hCC, 1'b0);
    applyStimulus(1'b1, 8'hDD, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("after_read_empty", r_data, 32'hDDCC_BBAA);
    checkState("after_read_empty", 0, 1'b1, 1'b0);

    // Streaming 40 bytes with opportunistic reads, bounded cycle budget
    n_wr = 0;
    n_rd = 0;
    for (int cyc = 0; cyc < 100 && n_rd < 10; cyc++) begin
      do_rd = ~r_empty;
      do_wr = (n_wr < 40);
      applyStimulus(do_wr, 8'(n_wr), do_rd);
      if (do_wr) n_wr++;
      if (do_rd) begin
        checkOutput($sformatf("stream%0d", n_rd), r_data, packWord(4 * n_rd));
        n_rd++;
      end
    end
    checkOutput("stream_count", 32'(n_rd), 32'd10);
    checkState("stream_end", 0, 1'b1, 1'b0);

    // Mid-operation reset with requests asserted
    for (int i = 0; i < 7; i++) applyStimulus(1'b1, 8'(8'h70 + i), 1'b0);
    checkState("pre_reset", 7, 1'b0, 1'b0);
    rst = 1'b1;
    applyStimulus(1'b1, 8'hEE, 1'b1);
    rst = 1'b0;
    checkState("mid_reset", 0, 1'b1, 1'b0);
    checkOutput("mid_reset_rdata", r_data, 32'h0000_0000);
    for (int i = 1; i <= 4; i++) applyStimulus(1'b1, 8'(i), 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("post_reset_word", r_data, 32'h0403_0201);
    checkState("post_reset", 0, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
